irq_controller_n: RTL and testbench

Parametrised interrupt controller for the AVR-style core. It replaces the fixed three-source timer interrupt logic with NUM_IRQ generic sources, each with a flag and a mask bit, gated by the global I bit in SREG. Arbitration is fixed-priority or round-robin. A request/acknowledge handshake with the CPU produces a one-cycle flag-clear strobe to the winning source.

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_arbiter.sv | 55 +++++
 rtl/irq_controller_n.sv | 96 +++++++++
 tb/tb_irq_controller_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the generic interrupt controller: FSM states,
// arbitration modes and the source-index width helper.
package irq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single source still needs a one-bit index.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection among eligible interrupt sources,
// either lowest-index-first or round-robin starting at rr_ptr.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ  = 8,
  parameter  int ARB_MODE = ARB_FIXED,
  localparam int ID_W     = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  if (ARB_MODE == ARB_RR) begin : g_rr
    logic [NUM_IRQ-1:0] rot;
    int                 ofs;
    int                 sum;

    // Rotate so that bit 0 of rot is the source at rr_ptr.
    assign rot = NUM_IRQ'({eligible, eligible} >> rr_ptr);

    always_comb begin
      valid  = 1'b0;
      winner = '0;
      ofs    = 0;
      sum    = 0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
        if (rot[k]) begin
          valid = 1'b1;
          ofs   = k;
        end
      end
      sum = int'(rr_ptr) + ofs;
      if (sum >= NUM_IRQ) sum = sum - NUM_IRQ;
      winner = ID_W'(sum);
    end
  end else begin : g_fixed
    logic unused_rr;
    assign unused_rr = ^rr_ptr;

    always_comb begin
      valid  = 1'b0;
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          valid  = 1'b1;
          winner = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/irq_controller_n.sv
// Generic N-source interrupt controller: gates flags by mask and SREG.I,
// latches one winner as an irq request and strobes its flag clear on ack.
module irq_controller_n
  import irq_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int I_ADDR_WIDTH  = 10,
  parameter  int NUM_IRQ       = 8,
  parameter  int VECTOR_BASE   = 1,
  parameter  int VECTOR_STRIDE = 1,
  parameter  int SREG_I_BIT    = 7,
  parameter  int ARB_MODE      = ARB_FIXED,
  localparam int ID_W          = id_width(NUM_IRQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IRQ-1:0]      irq_flags,
  input  logic [NUM_IRQ-1:0]      irq_mask,
  input  logic [DATA_WIDTH-1:0]   mem_sreg,
  input  logic                    irq_ack,
  output logic                    irq,
  output logic [I_ADDR_WIDTH-1:0] vector,
  output logic [ID_W-1:0]         irq_id,
  output logic [NUM_IRQ-1:0]      flag_clr
);

  if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
    $error("irq_controller_n: NUM_IRQ must be in 1..32");
  end
  if ((longint'(VECTOR_BASE) + longint'(NUM_IRQ - 1) * longint'(VECTOR_STRIDE))
      >= (longint'(1) << I_ADDR_WIDTH)) begin : g_bad_vector
    $error("irq_controller_n: highest vector does not fit in I_ADDR_WIDTH");
  end

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] latched_onehot;
  logic               latched_ok;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_winner;
  logic               unused_sreg;

  assign unused_sreg    = ^mem_sreg;
  assign eligible       = irq_flags & irq_mask & {NUM_IRQ{mem_sreg[SREG_I_BIT]}};
  assign latched_onehot = NUM_IRQ'(1) << irq_id;
  assign latched_ok     = |(eligible & latched_onehot);

  irq_arbiter #(
    .NUM_IRQ  (NUM_IRQ),
    .ARB_MODE (ARB_MODE)
  ) u_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      irq      <= 1'b0;
      vector   <= '0;
      irq_id   <= '0;
      flag_clr <= '0;
      rr_ptr   <= '0;
    end else begin
      flag_clr <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            irq    <= 1'b1;
            irq_id <= arb_winner;
            vector <= I_ADDR_WIDTH'(VECTOR_BASE + int'(arb_winner) * VECTOR_STRIDE);
            state  <= REQ;
          end
        end
        REQ: begin
          // Ack wins over a same-cycle withdrawal of the latched source.
          if (irq_ack) begin
            irq      <= 1'b0;
            flag_clr <= latched_onehot;
            state    <= IDLE;
            if (ARB_MODE == ARB_RR)
              rr_ptr <= (int'(irq_id) == NUM_IRQ - 1) ? '0 : irq_id + 1'b1;
          end else if (!latched_ok) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller_n.sv
// Bench for irq_controller_n: fixed-priority and round-robin instances share
// stimulus; a behavioural model, a vector table and hand sequences check them.
module tb_irq_controller_n;

  logic       clk;
  logic       reset;
  logic [3:0] flags;
  logic [3:0] mask;
  logic [7:0] sreg;
  logic       ack;

  logic       irq_fx, irq_rr;
  logic [9:0] vec_fx, vec_rr;
  logic [1:0] id_fx, id_rr;
  logic [3:0] clr_fx, clr_rr;

  int total = 0;
  int bad   = 0;

  int m_irq[2], m_id[2], m_vec[2], m_clr[2], m_ptr[2];

  irq_controller_n #(
    .DATA_WIDTH(8), .I_ADDR_WIDTH(10), .NUM_IRQ(4), .VECTOR_BASE(16),
    .VECTOR_STRIDE(2), .SREG_I_BIT(7), .ARB_MODE(0)
  ) dut_fx (
    .clk(clk), .reset(reset), .irq_flags(flags), .irq_mask(mask),
    .mem_sreg(sreg), .irq_ack(ack), .irq(irq_fx), .vector(vec_fx),
    .irq_id(id_fx), .flag_clr(clr_fx)
  );

  irq_controller_n #(
    .DATA_WIDTH(8), .I_ADDR_WIDTH(10), .NUM_IRQ(4), .VECTOR_BASE(16),
    .VECTOR_STRIDE(2), .SREG_I_BIT(7), .ARB_MODE(1)
  ) dut_rr (
    .clk(clk), .reset(reset), .irq_flags(flags), .irq_mask(mask),
    .mem_sreg(sreg), .irq_ack(ack), .irq(irq_rr), .vector(vec_rr),
    .irq_id(id_rr), .flag_clr(clr_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Search upward from start with wrap-around; start is 0 for fixed priority.
  function automatic int pick(input int elig, input int start);
    for (int k = 0; k < 4; k++) begin
      if (((elig >> ((start + k) % 4)) & 1) == 1) return (start + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_irq[m] = 0; m_id[m] = 0; m_vec[m] = 0; m_clr[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic cycle();
    int n_irq[2], n_id[2], n_vec[2], n_clr[2], n_ptr[2];
    int elig, w;
    elig = sreg[7] ? int'(flags & mask) : 0;
    for (int m = 0; m < 2; m++) begin
      n_irq[m] = m_irq[m]; n_id[m] = m_id[m]; n_vec[m] = m_vec[m];
      n_ptr[m] = m_ptr[m]; n_clr[m] = 0;
      if (m_irq[m] == 0) begin
        if (elig != 0) begin
          w = pick(elig, (m == 1) ? m_ptr[m] : 0);
          n_irq[m] = 1; n_id[m] = w; n_vec[m] = (16 + 2 * w) % 1024;
        end
      end else if (ack) begin
        n_irq[m] = 0;
        n_clr[m] = 1 << m_id[m];
        if (m == 1) n_ptr[m] = (m_id[m] + 1) % 4;
      end else if (((elig >> m_id[m]) & 1) == 0) begin
        n_irq[m] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      m_irq[m] = n_irq[m]; m_id[m] = n_id[m]; m_vec[m] = n_vec[m];
      m_clr[m] = n_clr[m]; m_ptr[m] = n_ptr[m];
    end
    check("fx_irq", 32'(irq_fx), m_irq[0]);
    check("fx_id",  32'(id_fx),  m_id[0]);
    check("fx_vec", 32'(vec_fx), m_vec[0]);
    check("fx_clr", 32'(clr_fx), m_clr[0]);
    check("rr_irq", 32'(irq_rr), m_irq[1]);
    check("rr_id",  32'(id_rr),  m_id[1]);
    check("rr_vec", 32'(vec_rr), m_vec[1]);
    check("rr_clr", 32'(clr_rr), m_clr[1]);
  endtask

  task automatic do_reset();
    flags = '0; mask = '0; sreg = '0; ack = 1'b0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] flags;
    logic [3:0] mask;
    logic [7:0] sreg;
    logic       ack;
    logic       exp_irq;
    logic [1:0] exp_id;
    logic [9:0] exp_vec;
    logic [3:0] exp_clr;
  } row_t;

  row_t tbl[16];
  int   rr_exp[6];
  bit   seen;

  initial begin
    flags = '0; mask = '0; sreg = '0; ack = 1'b0; reset = 1'b0;
    model_reset();
    #12;
    check("rst_irq", 32'(irq_fx), 0);
    check("rst_vec", 32'(vec_fx), 0);
    check("rst_id",  32'(id_fx),  0);
    check("rst_clr", 32'(clr_fx), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    //            flags    mask     sreg   ack   irq   id    vec     clr
    tbl[0]  = '{4'b0100, 4'b1111, 8'h80, 1'b0, 1'b1, 2'd2, 10'h014, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b1111, 8'h80, 1'b1, 1'b0, 2'd2, 10'h014, 4'b0100};
    tbl[2]  = '{4'b0000, 4'b1111, 8'h80, 1'b0, 1'b0, 2'd2, 10'h014, 4'b0000};
    tbl[3]  = '{4'b1010, 4'b1111, 8'h80, 1'b0, 1'b1, 2'd1, 10'h012, 4'b0000};
    tbl[4]  = '{4'b1011, 4'b1111, 8'h80, 1'b0, 1'b1, 2'd1, 10'h012, 4'b0000};
    tbl[5]  = '{4'b1011, 4'b1111, 8'h80, 1'b1, 1'b0, 2'd1, 10'h012, 4'b0010};
    tbl[6]  = '{4'b0000, 4'b1111, 8'h00, 1'b0, 1'b0, 2'd1, 10'h012, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b1111, 8'h00, 1'b0, 1'b0, 2'd1, 10'h012, 4'b0000};
    tbl[8]  = '{4'b1111, 4'b1111, 8'h7F, 1'b1, 1'b0, 2'd1, 10'h012, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b0000, 8'h80, 1'b0, 1'b0, 2'd1, 10'h012, 4'b0000};
    tbl[10] = '{4'b1111, 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd1, 10'h012, 4'b0000};
    tbl[11] = '{4'b1111, 4'b0001, 8'h80, 1'b0, 1'b1, 2'd0, 10'h010, 4'b0000};
    tbl[12] = '{4'b1111, 4'b0001, 8'h00, 1'b0, 1'b0, 2'd0, 10'h010, 4'b0000};
    tbl[13] = '{4'b0100, 4'b1111, 8'h80, 1'b0, 1'b1, 2'd2, 10'h014, 4'b0000};
    tbl[14] = '{4'b0000, 4'b1111, 8'h80, 1'b1, 1'b0, 2'd2, 10'h014, 4'b0100};
    tbl[15] = '{4'b0000, 4'b1111, 8'h80, 1'b0, 1'b0, 2'd2, 10'h014, 4'b0000};

    for (int i = 0; i < 16; i++) begin
      flags = tbl[i].flags; mask = tbl[i].mask; sreg = tbl[i].sreg; ack = tbl[i].ack;
      cycle();
      check($sformatf("tbl%0d_irq", i), 32'(irq_fx), 32'(tbl[i].exp_irq));
      check($sformatf("tbl%0d_id", i),  32'(id_fx),  32'(tbl[i].exp_id));
      check($sformatf("tbl%0d_vec", i), 32'(vec_fx), 32'(tbl[i].exp_vec));
      check($sformatf("tbl%0d_clr", i), 32'(clr_fx), 32'(tbl[i].exp_clr));
    end

    // Round-robin grant order with sources never cleared.
    do_reset();
    rr_exp = '{0, 1, 3, 0, 1, 3};
    flags = 4'b1011; mask = 4'b1111; sreg = 8'h80; ack = 1'b0;
    for (int g = 0; g < 6; g++) begin
      seen = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
        cycle();
        if (irq_rr) seen = 1'b1;
      end
      check($sformatf("rr_grant%0d_seen", g), 32'(seen), 1);
      check($sformatf("rr_grant%0d_id", g), 32'(id_rr), rr_exp[g]);
      ack = 1'b1;
      cycle();
      check($sformatf("rr_grant%0d_clr", g), 32'(clr_rr), 32'(1) << rr_exp[g]);
      ack = 1'b0;
    end

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) flags = 4'($urandom_range(0, 15));
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      sreg = 8'($urandom_range(0, 255));
      sreg[7] = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of a request.
    do_reset();
    flags = 4'b0100; mask = 4'b1111; sreg = 8'h80; ack = 1'b0;
    cycle();
    check("areset_pre_irq", 32'(irq_fx), 1);
    #3;
    reset = 1'b0;
    #1;
    check("areset_irq",    32'(irq_fx), 0);
    check("areset_vec",    32'(vec_fx), 0);
    check("areset_id",     32'(id_fx),  0);
    check("areset_clr",    32'(clr_fx), 0);
    check("areset_rr_irq", 32'(irq_rr), 0);
    check("areset_rr_vec", 32'(vec_rr), 0);
    model_reset();
    flags = '0; ack = 1'b1;
    #2;
    reset = 1'b1;
    cycle();
    ack = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
